// File: rtl/pnr_pkg.sv
// Shared types and defaults for the photon-number-resolving discriminator.
package pnr_pkg;

  localparam int N_CH_DEF   = 32'sd2;
  localparam int ADC_W_DEF  = 32'sd14;
  localparam int N_LVL_DEF  = 32'sd7;
  localparam int HOLD_W_DEF = 32'sd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEAK = 2'd1,
    ST_HOLD = 2'd2
  } pnr_state_e;

  // Ceiling log2, never below one bit so a single-level ladder still has a port.
  function automatic int pnr_clog2(input int value);
    int w;
    w = 32'sd0;
    while ((32'sd1 <<< w) < value) begin
      w = w + 32'sd1;
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/pnr_channel.sv
// One discriminator channel: input register, optional baseline stage (PNR_BASELINE_EN),
// IDLE/PEAK/HOLD state machine, peak tracker, holdoff counter and level ladder.
module pnr_channel
  import pnr_pkg::*;
#(
  parameter int ADC_W  = ADC_W_DEF,
  parameter int N_LVL  = N_LVL_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int PN_W   = pnr_clog2(N_LVL_DEF + 32'sd1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADC_W-1:0]         adc,
  input  logic [ADC_W-1:0]         trig_thr,
  input  logic [N_LVL*ADC_W-1:0]   lvl_thr,
  input  logic [HOLD_W-1:0]        holdoff,
  input  logic [ADC_W-1:0]         baseline,
  output logic                     ev_valid,
  output logic [PN_W-1:0]          ev_pn,
  output logic [ADC_W-1:0]         ev_peak,
  output logic                     busy
);

  logic signed [ADC_W-1:0] adc_r;
  logic signed [ADC_W-1:0] x_s;
  logic signed [ADC_W-1:0] thr_s;
  logic signed [ADC_W-1:0] peak_r;
  logic [HOLD_W-1:0]       cnt_r;
  logic                    done_r;
  logic [PN_W-1:0]         pn_s;
  pnr_state_e              state_r;

  assign thr_s = $signed(trig_thr);

  // Sample register straight off the ADC bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_r <= '0;
    end else begin
      adc_r <= $signed(adc);
    end
  end

`ifdef PNR_BASELINE_EN
  logic signed [ADC_W:0]   diff_s;
  logic signed [ADC_W-1:0] sat_s;
  logic signed [ADC_W-1:0] corr_r;

  // One extra bit keeps the subtraction exact; a sign/MSB disagreement means it left the ADC range.
  always_comb begin
    diff_s = {adc_r[ADC_W-1], adc_r} - {baseline[ADC_W-1], baseline};
    if (diff_s[ADC_W] != diff_s[ADC_W-1]) begin
      sat_s = {diff_s[ADC_W], {(ADC_W-1){~diff_s[ADC_W]}}};
    end else begin
      sat_s = diff_s[ADC_W-1:0];
    end
  end

  // Baseline-corrected sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_r <= '0;
    end else begin
      corr_r <= sat_s;
    end
  end

  assign x_s = corr_r;
`else
  logic unused_baseline_s;
  assign unused_baseline_s = ^baseline;
  assign x_s = adc_r;
`endif

  // Photon number: count of level thresholds strictly below the captured peak.
  always_comb begin
    pn_s = '0;
    for (int k = 32'sd0; k < N_LVL; k++) begin
      if (peak_r > $signed(lvl_thr[k*ADC_W +: ADC_W])) begin
        pn_s = pn_s + PN_W'(1'b1);
      end else begin
        pn_s = pn_s;
      end
    end
  end

  // Pulse state machine with registered event and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      peak_r   <= '0;
      cnt_r    <= '0;
      done_r   <= 1'b0;
      busy     <= 1'b0;
      ev_valid <= 1'b0;
      ev_pn    <= '0;
      ev_peak  <= '0;
    end else begin
      done_r   <= 1'b0;
      busy     <= (state_r != ST_IDLE);
      ev_valid <= done_r;
      if (done_r) begin
        ev_pn   <= pn_s;
        ev_peak <= peak_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (x_s > thr_s) begin
            state_r <= ST_PEAK;
            peak_r  <= x_s;
          end
        end
        ST_PEAK: begin
          // The falling sample closes the pulse and is never a peak candidate.
          if (x_s <= thr_s) begin
            done_r <= 1'b1;
            if (holdoff == {HOLD_W{1'b0}}) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_HOLD;
              cnt_r   <= holdoff;
            end
          end else if (x_s > peak_r) begin
            peak_r <= x_s;
          end
        end
        ST_HOLD: begin
          if (cnt_r <= HOLD_W'(1'b1)) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r - HOLD_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pnr_discriminator.sv
// N_CH-channel photon-number-resolving discriminator on ADC_CLK; define PNR_BASELINE_EN
// to add per-channel saturating baseline subtraction (one extra cycle of latency).
module pnr_discriminator
  import pnr_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int ADC_W  = ADC_W_DEF,
  parameter int N_LVL  = N_LVL_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int PN_W   = pnr_clog2(N_LVL + 32'sd1)
) (
  input  logic                    ADC_CLK,
  input  logic                    ADC_RSTN,
  input  logic [N_CH*ADC_W-1:0]   adc_data,
  input  logic [ADC_W-1:0]        trig_thr,
  input  logic [N_LVL*ADC_W-1:0]  lvl_thr,
  input  logic [HOLD_W-1:0]       holdoff,
  input  logic [N_CH*ADC_W-1:0]   baseline,
  output logic [N_CH-1:0]         ev_valid,
  output logic [N_CH*PN_W-1:0]    ev_pn,
  output logic [N_CH*ADC_W-1:0]   ev_peak,
  output logic [N_CH-1:0]         busy
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pnr_channel #(
      .ADC_W  (ADC_W),
      .N_LVL  (N_LVL),
      .HOLD_W (HOLD_W),
      .PN_W   (PN_W)
    ) u_ch (
      .clk      (ADC_CLK),
      .rst_n    (ADC_RSTN),
      .adc      (adc_data[g*ADC_W +: ADC_W]),
      .trig_thr (trig_thr),
      .lvl_thr  (lvl_thr),
      .holdoff  (holdoff),
      .baseline (baseline[g*ADC_W +: ADC_W]),
      .ev_valid (ev_valid[g]),
      .ev_pn    (ev_pn[g*PN_W +: PN_W]),
      .ev_peak  (ev_peak[g*ADC_W +: ADC_W]),
      .busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_pnr_discriminator.sv
// Scoreboard bench for pnr_discriminator: sample-indexed reference model feeds an expected-event queue.
module tb_pnr_discriminator;

  localparam int N_CH = 2, ADC_W = 14, N_LVL = 7, HOLD_W = 8, PN_W = 3;
`ifdef PNR_BASELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_CH*ADC_W-1:0]  adc_data = '0;
  logic [ADC_W-1:0]       trig_thr;
  logic [N_LVL*ADC_W-1:0] lvl_thr;
  logic [HOLD_W-1:0]      holdoff;
  logic [N_CH*ADC_W-1:0]  baseline;
  logic [N_CH-1:0]        ev_valid;
  logic [N_CH*PN_W-1:0]   ev_pn;
  logic [N_CH*ADC_W-1:0]  ev_peak;
  logic [N_CH-1:0]        busy;

  pnr_discriminator dut (
    .ADC_CLK(clk), .ADC_RSTN(rst_n), .adc_data(adc_data), .trig_thr(trig_thr),
    .lvl_thr(lvl_thr), .holdoff(holdoff), .baseline(baseline),
    .ev_valid(ev_valid), .ev_pn(ev_pn), .ev_peak(ev_peak), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0, failures = 0;
  int trig, hold, last_n;
  int lvl [N_LVL];
  int bl  [N_CH];

  always_comb begin
    trig_thr = ADC_W'(trig);
    holdoff  = HOLD_W'(hold);
    lvl_thr  = '0;
    baseline = '0;
    for (int k = 0; k < N_LVL; k++) lvl_thr[k*ADC_W +: ADC_W] = ADC_W'(lvl[k]);
    for (int c = 0; c < N_CH; c++) baseline[c*ADC_W +: ADC_W] = ADC_W'(bl[c]);
  end

  typedef struct {int ch; int cyc; int pn; int peak;} ev_t;
  ev_t exp_q[$];

  bit in_pulse [N_CH];
  int pk_m     [N_CH];
  int next_arm [N_CH];
  bit busy_hist [N_CH][16384];
  int evcnt [N_CH], last_pn [N_CH], last_peak [N_CH], last_cyc [N_CH];

  function automatic int sat_x(input int raw, input int b);
`ifdef PNR_BASELINE_EN
    int d;
    d = raw - b;
    if (d > 8191) return 8191;
    if (d < -8192) return -8192;
    return d;
`else
    return raw;
`endif
  endfunction

  function automatic int classify(input int p);
    int n;
    n = 0;
    foreach (lvl[k]) if (p > lvl[k]) n++;
    return n;
  endfunction

  // Reference: processes sample n of channel c against the spec rules.
  task automatic model(input int c, input int s, input int n, input bit rst);
    int x;
    ev_t e;
    if (rst) begin
      in_pulse[c] = 1'b0;
      next_arm[c] = 0;
      busy_hist[c][n] = 1'b0;
      return;
    end
    x = sat_x(s, bl[c]);
    if (in_pulse[c]) begin
      if (x <= trig) begin
        e.ch = c; e.cyc = n + LAT; e.pn = classify(pk_m[c]); e.peak = pk_m[c];
        exp_q.push_back(e);
        in_pulse[c] = 1'b0;
        next_arm[c] = n + hold + 1;
      end else if (x > pk_m[c]) begin
        pk_m[c] = x;
      end
    end else if (n >= next_arm[c] && x > trig) begin
      in_pulse[c] = 1'b1;
      pk_m[c] = x;
    end
    busy_hist[c][n] = in_pulse[c] || (next_arm[c] > n + 1);
  endtask

  task automatic step(input int s0, input int s1, input bit rst);
    @(negedge clk);
    rst_n = ~rst;
    adc_data = {ADC_W'(s1), ADC_W'(s0)};
    last_n = edge_cnt + 1;
    model(0, s0, last_n, rst);
    model(1, s1, last_n, rst);
  endtask

  task automatic quiet(input int k);
    repeat (k) step(0, 0, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: pops the scoreboard whenever a channel strobes, and checks busy every cycle.
  initial begin
    int idx, pn_a, pk_a;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1) begin
        for (int c = 0; c < N_CH; c++) begin
          if (edge_cnt >= LAT) check($sformatf("busy_ch%0d", c), int'(busy[c]), int'(busy_hist[c][edge_cnt-LAT]));
          if (ev_valid[c] === 1'b1) begin
            pn_a = int'(ev_pn[c*PN_W +: PN_W]);
            pk_a = int'($signed(ev_peak[c*ADC_W +: ADC_W]));
            evcnt[c]++; last_pn[c] = pn_a; last_peak[c] = pk_a; last_cyc[c] = edge_cnt;
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == c) idx = i;
            if (idx < 0) begin
              checks++; failures++;
              $display("FAIL spurious_event_ch%0d: got ev_valid=1 expected 0 (cycle %0d)", c, edge_cnt);
            end else begin
              check($sformatf("event_cycle_ch%0d", c), edge_cnt, exp_q[idx].cyc);
              check($sformatf("event_pn_ch%0d", c), pn_a, exp_q[idx].pn);
              check($sformatf("event_peak_ch%0d", c), pk_a, exp_q[idx].peak);
              exp_q.delete(idx);
            end
          end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].cyc < edge_cnt) begin
            checks++; failures++;
            $display("FAIL missed_event_ch%0d: got no ev_valid expected one at cycle %0d", exp_q[i].ch, exp_q[i].cyc);
            exp_q.delete(i);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e0, e1, nm;
    trig = 100; hold = 0;
    for (int k = 0; k < N_LVL; k++) lvl[k] = 200 * (k + 1);
    for (int c = 0; c < N_CH; c++) bl[c] = 0;

    // Reset with a large pulse present
    repeat (3) step(5000, 5000, 1'b1);
    @(posedge clk); #1;
    check("reset_ev_valid", int'(ev_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ev_pn", int'(ev_pn), 0);
    check("reset_ev_peak", int'(ev_peak), 0);
    quiet(10);
    check("post_reset_no_event", evcnt[0] + evcnt[1], 0);

    // Single pulse on ch0
    e0 = evcnt[0];
    step(0, 0, 0); step(150, 0, 0); step(450, 0, 0); step(300, 0, 0); step(50, 0, 0);
    nm = last_n;
    quiet(6);
    check("single_count", evcnt[0] - e0, 1);
    check("single_peak", last_peak[0], 450);
    check("single_pn", last_pn[0], 2);
    check("single_latency", last_cyc[0], nm + LAT);

    // Sample equal to trigger threshold
    e0 = evcnt[0]; e1 = evcnt[1];
    step(100, 100, 0); quiet(6);
    check("equal_trig_ch0", evcnt[0] - e0, 0);
    check("equal_trig_ch1", evcnt[1] - e1, 0);

    // Peak equal to lowest level, then full-scale peak
    step(200, 0, 0); step(50, 0, 0); quiet(5);
    check("peak_eq_lvl0_pn", last_pn[0], 0);
    check("peak_eq_lvl0_peak", last_peak[0], 200);
    step(8191, 0, 0); step(0, 0, 0); quiet(5);
    check("peak_max_pn", last_pn[0], 7);
    check("peak_max_peak", last_peak[0], 8191);

    // Reset while in PEAK
    e0 = evcnt[0];
    step(500, 0, 0); step(700, 0, 0);
    repeat (3) step(700, 0, 1'b1);
    step(50, 0, 0); quiet(6);
    check("reset_midpulse_no_event", evcnt[0] - e0, 0);

    // Holdoff of 4
    hold = 4; quiet(2);
    e0 = evcnt[0];
    step(300, 0, 0); step(50, 0, 0); nm = last_n;
    step(0, 0, 0); step(500, 0, 0); step(50, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1000, 0, 0); step(50, 0, 0);
    quiet(10);
    check("holdoff_count", evcnt[0] - e0, 2);
    check("holdoff_pn", last_pn[0], 4);
    check("holdoff_peak", last_peak[0], 1000);
    check("holdoff_latency", last_cyc[0], nm + 7 + LAT);
    hold = 0; quiet(2);

    // Simultaneous pulses on both channels
    step(450, 1000, 0); step(50, 50, 0); nm = last_n; quiet(6);
    check("indep_cycle_ch0", last_cyc[0], nm + LAT);
    check("indep_cycle_ch1", last_cyc[1], nm + LAT);
    check("indep_pn_ch0", last_pn[0], 2);
    check("indep_pn_ch1", last_pn[1], 4);

    // Baseline correction and saturation
    step(-2000, 0, 0);
    bl[0] = -1000;
    step(-2000, 0, 0); step(-2000, 0, 0); step(8000, 0, 0); step(-2000, 0, 0);
    nm = last_n;
    repeat (3) step(-2000, 0, 0);
    bl[0] = 0;
    repeat (2) step(-2000, 0, 0);
    quiet(6);
`ifdef PNR_BASELINE_EN
    check("baseline_peak", last_peak[0], 8191);
`else
    check("baseline_peak", last_peak[0], 8000);
`endif
    check("baseline_pn", last_pn[0], 7);
    check("baseline_latency", last_cyc[0], nm + LAT);

    // Randomised segments with fresh thresholds each time
    for (int seg = 0; seg < 6; seg++) begin
      trig = 400 + int'($urandom_range(0, 1600));
      hold = int'($urandom_range(0, 10));
      lvl[0] = int'($urandom_range(0, 1000)) - 500;
      for (int k = 1; k < N_LVL; k++) lvl[k] = lvl[k-1] + 1 + int'($urandom_range(0, 999));
      for (int c = 0; c < N_CH; c++) bl[c] = int'($urandom_range(0, 600)) - 300;
      quiet(1);
      repeat (300) begin
        int s [N_CH];
        for (int c = 0; c < N_CH; c++) begin
          if ($urandom_range(0, 3) == 0) s[c] = int'($urandom_range(0, 16383)) - 8192;
          else s[c] = trig + int'($urandom_range(0, 600)) - 300;
        end
        step(s[0], s[1], 0);
      end
      quiet(hold + 8);
    end

    quiet(20);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
